// File: rtl/cheat_pgm_sequencer_pkg.sv
// Shared types and constants for the cheat engine programming sequencer.
// Optional build macro: CHEAT_PGM_READBACK_EN (adds the per-index readback shadow file).
package cheat_pgm_pkg;

  localparam int unsigned NSLOTS      = 6;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned FIFO_AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned MASK_W      = NSLOTS;

  localparam logic [2:0] PGM_IDX_MASK   = 3'd6;
  localparam logic [2:0] PGM_IDX_GLOBAL = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    MASK_OFF,
    DRAIN,
    MASK_ON
  } state_e;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/cheat_pgm_sequencer_if.sv
// MCU command bus into the sequencer: frame delimiting, byte strobes and commit.
interface cheat_pgm_sequencer_if;
  import cheat_pgm_pkg::*;

  logic       frame_start;
  logic       wr_strobe;
  logic [7:0] data;
  logic       commit;

  modport master (output frame_start, output wr_strobe, output data, output commit);
  modport slave  (input  frame_start, input  wr_strobe, input  data, input  commit);
endinterface

// File: rtl/cheat_pgm_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO of slot entries; a pop frees room for a same-cycle push.
module cheat_pgm_fifo
  import cheat_pgm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  entry_t             entry_i,
  input  logic               pop_i,
  output entry_t             entry_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  entry_t             mem_q [FIFO_DEPTH];
  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
  logic               do_push, do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == (FIFO_AW+1)'(FIFO_DEPTH));
  assign entry_o = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/cheat_pgm_sequencer.sv
// Frame assembler, entry queue and atomic mask-off/drain/mask-on apply for the cheat engine port.
// Optional build macro: CHEAT_PGM_READBACK_EN adds rb_idx_i/rb_data_o readback of completed writes.
module cheat_pgm_sequencer
  import cheat_pgm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cheat_pgm_sequencer_if.slave mcu,
  input  logic                 snescmd_wr_busy_i,
  output logic [2:0]           pgm_idx_o,
  output logic                 pgm_we_o,
  output logic [31:0]          pgm_in_o,
  output logic                 busy_o,
  output logic                 fifo_full_o,
  output logic                 err_overflow_o,
  output logic                 err_frame_o,
  output logic                 done_o
`ifdef CHEAT_PGM_READBACK_EN
  ,
  input  logic [2:0]           rb_idx_i,
  output logic [31:0]          rb_data_o
`endif
);

  localparam int unsigned      BCNT_W    = 3;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);
  localparam logic [BCNT_W-1:0] SPENT     = BCNT_W'(FRAME_BYTES);

  logic [BCNT_W-1:0] bcnt_q, bcnt_d, bcnt_eff;
  logic              discard_q, discard_d, discard_eff;
  logic [2:0]        aidx_q, aidx_d;
  logic [23:0]       adata_q, adata_d;
  logic              err_frame_q, err_frame_d, err_ovf_q, err_ovf_d;
  logic              push_c, pop_c;
  entry_t            push_entry, head;
  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_count;

  state_e            state_q, state_d;
  logic              pgm_we_q, we_d, busy_q, done_q, done_d;
  logic [2:0]        pgm_idx_q, idx_d;
  logic [31:0]       pgm_in_q, in_d;
  logic [MASK_W-1:0] new_mask_q, new_mask_d, shadow_mask_q, shadow_mask_d;
  logic              wr_done_c;

  cheat_pgm_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .entry_i (push_entry),
    .pop_i   (pop_c),
    .entry_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Byte assembler: frame_start restarts at byte 0 even if a strobe lands in the same cycle.
  always_comb begin
    bcnt_eff    = mcu.frame_start ? '0 : bcnt_q;
    discard_eff = mcu.frame_start ? 1'b0 : discard_q;
    bcnt_d      = bcnt_eff;
    discard_d   = discard_eff;
    aidx_d      = aidx_q;
    adata_d     = adata_q;
    push_c      = 1'b0;
    push_entry  = {aidx_q, adata_q, mcu.data};
    err_frame_d = mcu.commit ? 1'b0 : err_frame_q;
    if (mcu.wr_strobe && !discard_eff && (bcnt_eff != SPENT)) begin
      if (bcnt_eff == '0) begin
        if (mcu.data[7:3] != 5'd0) begin
          discard_d   = 1'b1;
          err_frame_d = 1'b1;
        end else begin
          aidx_d = mcu.data[2:0];
          bcnt_d = BCNT_W'(1);
        end
      end else if (bcnt_eff == LAST_BYTE) begin
        push_c = 1'b1;
        bcnt_d = SPENT;
      end else begin
        adata_d = {adata_q[15:0], mcu.data};
        bcnt_d  = bcnt_eff + BCNT_W'(1);
      end
    end
    err_ovf_d = (mcu.commit ? 1'b0 : err_ovf_q) | (push_c && fifo_full && !pop_c);
  end

  assign wr_done_c = pgm_we_q && !snescmd_wr_busy_i;

  // Apply FSM; a write is retried with identical idx/data until a cycle without snescmd collision.
  always_comb begin
    state_d       = state_q;
    we_d          = pgm_we_q;
    idx_d         = pgm_idx_q;
    in_d          = pgm_in_q;
    new_mask_d    = new_mask_q;
    shadow_mask_d = shadow_mask_q;
    done_d        = 1'b0;
    pop_c         = 1'b0;
    case (state_q)
      IDLE: begin
        if (mcu.commit) begin
          if (fifo_empty) begin
            done_d = 1'b1;
          end else begin
            new_mask_d = shadow_mask_q;
            state_d    = MASK_OFF;
          end
        end
      end
      MASK_OFF: begin
        if (!pgm_we_q) begin
          we_d  = 1'b1;
          idx_d = PGM_IDX_MASK;
          in_d  = '0;
        end else if (wr_done_c) begin
          we_d    = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pgm_we_q) begin
          if (wr_done_c) we_d = 1'b0;
        end else if (!fifo_empty) begin
          pop_c = 1'b1;
          if (head.idx == PGM_IDX_MASK) begin
            new_mask_d = head.data[MASK_W-1:0];
          end else begin
            we_d  = 1'b1;
            idx_d = head.idx;
            in_d  = head.data;
          end
        end else begin
          we_d    = 1'b1;
          idx_d   = PGM_IDX_MASK;
          in_d    = 32'(new_mask_q);
          state_d = MASK_ON;
        end
      end
      MASK_ON: begin
        if (wr_done_c) begin
          we_d          = 1'b0;
          shadow_mask_d = new_mask_q;
          done_d        = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q        <= '0;
      discard_q     <= 1'b0;
      aidx_q        <= '0;
      adata_q       <= '0;
      err_frame_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
      state_q       <= IDLE;
      pgm_we_q      <= 1'b0;
      pgm_idx_q     <= '0;
      pgm_in_q      <= '0;
      new_mask_q    <= '0;
      shadow_mask_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      bcnt_q        <= bcnt_d;
      discard_q     <= discard_d;
      aidx_q        <= aidx_d;
      adata_q       <= adata_d;
      err_frame_q   <= err_frame_d;
      err_ovf_q     <= err_ovf_d;
      state_q       <= state_d;
      pgm_we_q      <= we_d;
      pgm_idx_q     <= idx_d;
      pgm_in_q      <= in_d;
      new_mask_q    <= new_mask_d;
      shadow_mask_q <= shadow_mask_d;
      busy_q        <= (state_d != IDLE);
      done_q        <= done_d;
    end
  end

  assign pgm_idx_o      = pgm_idx_q;
  assign pgm_we_o       = pgm_we_q;
  assign pgm_in_o       = pgm_in_q;
  assign busy_o         = busy_q;
  assign fifo_full_o    = (fifo_count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign err_overflow_o = err_ovf_q;
  assign err_frame_o    = err_frame_q;
  assign done_o         = done_q;

`ifdef CHEAT_PGM_READBACK_EN
  logic [31:0] rb_q [8];

  // Last value the cheat engine actually accepted for each index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rb_q[i] <= '0;
    end else if (wr_done_c) begin
      rb_q[pgm_idx_q] <= pgm_in_q;
    end
  end

  assign rb_data_o = rb_q[rb_idx_i];
`endif

endmodule
